async_fifo_rd_packer: RTL and testbench

Read-domain consumer that sits directly downstream of the async FIFO read port. It pops narrow entries from the FIFO, assembles PACK consecutive entries into one wide word (first entry in the least-significant lane), and presents that word on a valid/ready output interface. A flush request emits any partial word early, together with its lane count. It runs entirely in the FIFO read clock domain.

---
 rtl/async_fifo_rd_pkg.sv | 12 +
 rtl/async_fifo_pack_outreg.sv | 51 +++++
 rtl/async_fifo_rd_packer.sv | 95 +++++++++
 tb/tb_async_fifo_rd_packer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_rd_pkg.sv
// Shared types and default sizing for the read-domain packer.
package async_fifo_rd_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned DEFAULT_PACK       = 4;
  localparam int unsigned DEFAULT_CNT_W      = $clog2(DEFAULT_PACK + 1);

  typedef enum logic {FILL, DRAIN} pack_state_t;

  typedef logic [DEFAULT_CNT_W-1:0] lane_cnt_t;

endpackage

// File: rtl/async_fifo_pack_outreg.sv
// Valid/ready holding register for packed words: load, hold under backpressure, clear on accept.
module async_fifo_pack_outreg #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic [CNT_W-1:0]  load_count,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_valid
);

  logic [WORD_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              valid_q, valid_d;

  // A load on the same edge as an accept replaces the old word.
  always_comb begin
    data_d  = data_q;
    count_d = count_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = load_data;
      count_d = load_count;
      valid_d = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_count = count_q;
  assign out_valid = valid_q;

endmodule

// File: rtl/async_fifo_rd_packer.sv
// Pops narrow FIFO entries, packs PACK of them (lane 0 first) into a wide valid/ready word; flush emits a partial word.
module async_fifo_rd_packer
  import async_fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned PACK       = DEFAULT_PACK,
  parameter int unsigned CNT_W      = $clog2(PACK + 1)
) (
  input  logic                       rclk,
  input  logic                       rrst,
  input  logic [DATA_WIDTH-1:0]      rdata,
  input  logic                       rempty,
  output logic                       rinc,
  input  logic                       flush,
  output logic [DATA_WIDTH*PACK-1:0] out_data,
  output logic [CNT_W-1:0]           out_count,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy
);

  localparam int unsigned WORD_W = DATA_WIDTH * PACK;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PACK);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  pack_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  lane;
  logic              fpend;
  logic              out_free;
  logic              xfer;
  logic              pop;

  assign fpend = (state_q == DRAIN);

  always_comb begin
    out_free = !out_valid || out_ready;
    xfer     = out_free && ((cnt_q == CNT_FULL) || (fpend && (cnt_q != '0)));
    pop      = !rrst && !rempty && !fpend && ((cnt_q < CNT_FULL) || xfer);

    // Clearing on transfer keeps unused lanes of a partial word at zero.
    lane  = xfer ? '0 : cnt_q;
    acc_d = xfer ? '0 : acc_q;
    if (pop) begin
      acc_d[32'(lane)*DATA_WIDTH +: DATA_WIDTH] = rdata;
    end

    cnt_d = cnt_q;
    case ({xfer, pop})
      2'b11:   cnt_d = CNT_ONE;
      2'b10:   cnt_d = '0;
      2'b01:   cnt_d = cnt_q + CNT_ONE;
      default: cnt_d = cnt_q;
    endcase

    state_d = state_q;
    case (state_q)
      FILL:    if (flush) state_d = DRAIN;
      DRAIN:   if (xfer || (cnt_q == '0)) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

  async_fifo_pack_outreg #(
    .WORD_W (WORD_W),
    .CNT_W  (CNT_W)
  ) u_outreg (
    .clk        (rclk),
    .rst        (rrst),
    .load       (xfer),
    .load_data  (acc_q),
    .load_count (cnt_q),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_count  (out_count),
    .out_valid  (out_valid)
  );

  assign rinc = pop;
  assign busy = (cnt_q != '0) || fpend || out_valid;

endmodule

// File: tb/tb_async_fifo_rd_packer.sv
// Directed checks of the PACK=4 packer plus a randomized PACK=2 stream check against a byte scoreboard.
module tb_async_fifo_rd_packer;

  logic        clk;
  logic        rrst;

  logic [7:0]  rdata;
  logic        rempty;
  logic        rinc;
  logic        flush;
  logic [31:0] out_data;
  logic [2:0]  out_count;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  logic [7:0]  rdata2;
  logic        rempty2;
  logic        rinc2;
  logic        flush2;
  logic [15:0] out_data2;
  logic [1:0]  out_count2;
  logic        out_valid2;
  logic        out_ready2;
  logic        busy2;

  async_fifo_rd_packer #(.DATA_WIDTH(8), .PACK(4)) u_dut (
    .rclk(clk), .rrst(rrst), .rdata(rdata), .rempty(rempty), .rinc(rinc),
    .flush(flush), .out_data(out_data), .out_count(out_count),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  async_fifo_rd_packer #(.DATA_WIDTH(8), .PACK(2)) u_dut2 (
    .rclk(clk), .rrst(rrst), .rdata(rdata2), .rempty(rempty2), .rinc(rinc2),
    .flush(flush2), .out_data(out_data2), .out_count(out_count2),
    .out_valid(out_valid2), .out_ready(out_ready2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0]  fq[$];
  logic [31:0] wq_data[$];
  int          wq_cnt[$];
  int          pops;
  int          cyc;
  int          first_pop;
  int          last_pop;

  logic [7:0]  fq2[$];
  logic [7:0]  exp2[$];
  logic [7:0]  got2[$];
  int          rnd_en;
  int          pushed2;
  int          viol;
  int          cnt2_bad;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Apply this cycle's inputs just after the falling edge and let them settle.
  task automatic drive();
    logic [7:0] b;
    if (rnd_en != 0 && pushed2 < 200 && fq2.size() < 3) begin
      b = 8'($urandom_range(0, 255));
      fq2.push_back(b);
      exp2.push_back(b);
      pushed2++;
    end
    rempty  = (fq.size() == 0);
    rdata   = (fq.size() != 0) ? fq[0] : 8'h00;
    rempty2 = (fq2.size() == 0) || (rnd_en != 0 && $urandom_range(0, 2) == 0);
    rdata2  = (fq2.size() != 0) ? fq2[0] : 8'h00;
    if (rnd_en != 0) out_ready2 = ($urandom_range(0, 1) == 1);
    #1;
  endtask

  // Record what the coming rising edge will consume, then move to the next falling edge.
  task automatic advance();
    if (rinc) begin
      pops++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
      if (fq.size() != 0) void'(fq.pop_front());
    end
    if (out_valid && out_ready) begin
      wq_data.push_back(out_data);
      wq_cnt.push_back(int'(out_count));
    end
    if (rinc2 && rempty2) viol++;
    if (rinc2 && fq2.size() != 0) void'(fq2.pop_front());
    if (out_valid2 && out_ready2) begin
      if (out_count2 != 2'd2) cnt2_bad++;
      for (int i = 0; i < int'(out_count2); i++) got2.push_back(out_data2[i*8 +: 8]);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      drive();
      advance();
    end
  endtask

  task automatic clear_words();
    wq_data.delete();
    wq_cnt.delete();
  endtask

  logic [31:0] first_word;
  int          seen;
  int          unstable;
  int          mism;

  initial begin
    rrst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    flush2 = 1'b0; out_ready2 = 1'b1;
    rdata = '0; rempty = 1'b1; rdata2 = '0; rempty2 = 1'b1;
    pops = 0; cyc = 0; first_pop = -1; last_pop = -1;
    rnd_en = 0; pushed2 = 0; viol = 0; cnt2_bad = 0;
    @(negedge clk);
    run(2);
    rrst = 1'b0;

    // Reset state
    drive();
    chk("rst_valid", out_valid, 0);
    chk("rst_count", out_count, 0);
    chk("rst_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rinc", rinc, 0);
    advance();

    // Two full words with no backpressure
    for (int i = 1; i <= 8; i++) fq.push_back(8'(i));
    pops = 0; first_pop = -1; clear_words();
    run(14);
    chk("p1_pops", pops, 8);
    chk("p1_consec", last_pop - first_pop + 1, 8);
    chk("p1_nwords", wq_data.size(), 2);
    if (wq_data.size() == 2) begin
      chk("p1_w0", wq_data[0], 32'h04030201);
      chk("p1_c0", wq_cnt[0], 4);
      chk("p1_w1", wq_data[1], 32'h08070605);
      chk("p1_c1", wq_cnt[1], 4);
    end

    // Partial word via flush; drain blocks pops even with data available
    clear_words(); pops = 0;
    fq.push_back(8'hAA); fq.push_back(8'hBB); fq.push_back(8'hCC);
    run(3);
    flush = 1'b1; drive(); advance(); flush = 1'b0;
    fq.push_back(8'hDD);
    drive();
    chk("drain_rinc", rinc, 0);
    chk("drain_busy", busy, 1);
    advance();
    drive();
    chk("fl_valid", out_valid, 1);
    chk("fl_data", out_data, 32'h00CCBBAA);
    chk("fl_count", out_count, 3);
    advance();
    flush = 1'b1; drive(); advance(); flush = 1'b0;
    run(3);
    drive();
    chk("fl_busy_low", busy, 0);
    advance();
    chk("fl_pops", pops, 4);
    chk("fl_nwords", wq_data.size(), 2);
    if (wq_data.size() == 2) begin
      chk("fl_w0", wq_data[0], 32'h00CCBBAA);
      chk("fl_c0", wq_cnt[0], 3);
      chk("fl_w1", wq_data[1], 32'h000000DD);
      chk("fl_c1", wq_cnt[1], 1);
    end

    // Backpressure: 8 pops then stall with the first word held
    clear_words(); pops = 0; out_ready = 1'b0;
    for (int i = 0; i < 10; i++) fq.push_back(8'(8'h10 + i));
    seen = 0; unstable = 0; first_word = '0;
    for (int i = 0; i < 20; i++) begin
      drive();
      if (out_valid) begin
        if (seen == 0) begin first_word = out_data; seen = 1; end
        else if (out_data != first_word) unstable++;
      end
      advance();
    end
    chk("bp_pops", pops, 8);
    drive();
    chk("bp_rinc", rinc, 0);
    chk("bp_word", first_word, 32'h13121110);
    chk("bp_stable", unstable, 0);
    advance();
    out_ready = 1'b1;
    run(10);
    chk("bp_pops_all", pops, 10);
    flush = 1'b1; drive(); advance(); flush = 1'b0;
    run(4);
    chk("bp_nwords", wq_data.size(), 3);
    if (wq_data.size() == 3) begin
      chk("bp_w0", wq_data[0], 32'h13121110);
      chk("bp_w1", wq_data[1], 32'h17161514);
      chk("bp_w2", wq_data[2], 32'h00001918);
      chk("bp_c2", wq_cnt[2], 2);
    end

    // Flush with nothing accumulated
    clear_words();
    flush = 1'b1; drive(); advance(); flush = 1'b0;
    drive();
    chk("ef_busy", busy, 1);
    chk("ef_valid", out_valid, 0);
    advance();
    drive();
    chk("ef_clear", busy, 0);
    advance();
    run(2);
    chk("ef_nwords", wq_data.size(), 0);

    // Reset mid-word discards both the held word and the partial accumulator
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) fq.push_back(8'(8'h30 + i));
    run(8);
    drive();
    chk("mr_valid", out_valid, 1);
    chk("mr_busy", busy, 1);
    advance();
    for (int i = 1; i <= 4; i++) fq.push_back(8'(8'h20 + i));
    rrst = 1'b1;
    drive();
    chk("mr_rinc", rinc, 0);
    advance();
    rrst = 1'b0; out_ready = 1'b1; clear_words();
    drive();
    chk("mr_valid0", out_valid, 0);
    chk("mr_data0", out_data, 0);
    chk("mr_count0", out_count, 0);
    chk("mr_busy0", busy, 0);
    advance();
    run(8);
    chk("mr_nwords", wq_data.size(), 1);
    if (wq_data.size() == 1) begin
      chk("mr_w0", wq_data[0], 32'h24232221);
      chk("mr_c0", wq_cnt[0], 4);
    end

    // Random empty/ready toggling on the PACK=2 instance
    rnd_en = 1;
    run(1500);
    rnd_en = 0; out_ready2 = 1'b1;
    run(10);
    chk("rn_pushed", pushed2, 200);
    chk("rn_len", got2.size(), exp2.size());
    mism = 0;
    for (int i = 0; i < got2.size() && i < exp2.size(); i++)
      if (got2[i] != exp2[i]) mism++;
    chk("rn_stream", mism, 0);
    chk("rn_empty_pop", viol, 0);
    chk("rn_count", cnt2_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
